// File: rtl/pwl_segment_select.sv
// Piecewise-linear coefficient selector: finds the segment of a sign-magnitude
// sample among N runtime-loadable breakpoints and emits that segment's slope/intercept.
module pwl_segment_select #(
    parameter int W  = 16,
    parameter int N  = 16,
    parameter int AW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_m,
    output logic [W-1:0]  out_c,
    output logic [AW-1:0] out_seg,
    input  logic          wr_en,
    input  logic [1:0]    wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    output logic          wr_ready
);

    logic [W-1:0]  bp_q [N];
    logic [W-1:0]  bp_d [N];
    logic [W-1:0]  m_q  [N+1];
    logic [W-1:0]  m_d  [N+1];
    logic [W-1:0]  c_q  [N+1];
    logic [W-1:0]  c_d  [N+1];
    logic          s1_valid_q, s1_valid_d;
    logic [N-1:0]  s1_flags_q, s1_flags_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_m_q, out_m_d;
    logic [W-1:0]  out_c_q, out_c_d;
    logic [AW-1:0] out_seg_q, out_seg_d;

    logic          s1_adv_s, s2_adv_s, wr_fire_s;
    logic          wr_bp_s, wr_m_s, wr_c_s, s2_load_s;
    logic [N-1:0]  flags_new_s;
    logic [AW-1:0] seg_s;
    logic [W-1:0]  m_sel_s, c_sel_s;

    // -0 is folded onto +0 so that both compare as the same value.
    function automatic logic lt_sm(input logic [W-1:0] a, input logic [W-1:0] b);
        logic a_neg;
        logic b_neg;
        a_neg = a[W-1] && (a[W-2:0] != '0);
        b_neg = b[W-1] && (b[W-2:0] != '0);
        if (a_neg != b_neg) begin
            return a_neg;
        end else if (!a_neg) begin
            return a[W-2:0] < b[W-2:0];
        end else begin
            return a[W-2:0] > b[W-2:0];
        end
    endfunction

    assign s2_adv_s  = !out_valid_q || out_ready;
    assign s1_adv_s  = !s1_valid_q || s2_adv_s;
    assign wr_ready  = !s1_valid_q && !out_valid_q && !in_valid;
    assign wr_fire_s = wr_en && wr_ready;
    // A write can only fire while in_valid is low, so gating in_ready with it is unnecessary.
    assign in_ready  = s1_adv_s;
    assign out_valid = out_valid_q;
    assign out_m     = out_m_q;
    assign out_c     = out_c_q;
    assign out_seg   = out_seg_q;

    // Table write decode; out-of-range addresses and wr_sel=3 are silently dropped.
    always_comb begin
        wr_bp_s = wr_fire_s && (wr_sel == 2'd0) && (wr_addr <  AW'(N));
        wr_m_s  = wr_fire_s && (wr_sel == 2'd1) && (wr_addr <= AW'(N));
        wr_c_s  = wr_fire_s && (wr_sel == 2'd2) && (wr_addr <= AW'(N));
        for (int j = 0; j < N; j++) begin
            bp_d[j] = (wr_bp_s && (wr_addr == AW'(j))) ? wr_data : bp_q[j];
        end
        for (int j = 0; j <= N; j++) begin
            m_d[j] = (wr_m_s && (wr_addr == AW'(j))) ? wr_data : m_q[j];
            c_d[j] = (wr_c_s && (wr_addr == AW'(j))) ? wr_data : c_q[j];
        end
    end

    // Stage 1: compare the incoming sample against every breakpoint.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            flags_new_s[j] = lt_sm(in_data, bp_q[j]);
        end
        s1_valid_d = s1_adv_s ? in_valid    : s1_valid_q;
        s1_flags_d = s1_adv_s ? flags_new_s : s1_flags_q;
    end

    // Stage 2: lowest set flag wins, then look up the coefficients.
    always_comb begin
        seg_s = AW'(N);
        for (int j = N - 1; j >= 0; j--) begin
            seg_s = s1_flags_q[j] ? AW'(j) : seg_s;
        end
        m_sel_s = '0;
        c_sel_s = '0;
        for (int j = 0; j <= N; j++) begin
            m_sel_s = (seg_s == AW'(j)) ? m_q[j] : m_sel_s;
            c_sel_s = (seg_s == AW'(j)) ? c_q[j] : c_sel_s;
        end
        s2_load_s   = s2_adv_s && s1_valid_q;
        out_valid_d = s2_adv_s  ? s1_valid_q : out_valid_q;
        out_m_d     = s2_load_s ? m_sel_s    : out_m_q;
        out_c_d     = s2_load_s ? c_sel_s    : out_c_q;
        out_seg_d   = s2_load_s ? seg_s      : out_seg_q;
    end

    // State registers; reset also wipes the coefficient tables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < N; j++) begin
                bp_q[j] <= '0;
            end
            for (int j = 0; j <= N; j++) begin
                m_q[j] <= '0;
                c_q[j] <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_flags_q  <= '0;
            out_valid_q <= 1'b0;
            out_m_q     <= '0;
            out_c_q     <= '0;
            out_seg_q   <= '0;
        end else begin
            bp_q        <= bp_d;
            m_q         <= m_d;
            c_q         <= c_d;
            s1_valid_q  <= s1_valid_d;
            s1_flags_q  <= s1_flags_d;
            out_valid_q <= out_valid_d;
            out_m_q     <= out_m_d;
            out_c_q     <= out_c_d;
            out_seg_q   <= out_seg_d;
        end
    end

endmodule

// File: tb/tb_pwl_segment_select.sv
// Self-checking bench for pwl_segment_select: directed vectors, random streams
// and handshake corner cases against a signed-integer reference model.
module tb_pwl_segment_select;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_m;
    logic [15:0] out_c;
    logic [4:0]  out_seg;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;

    pwl_segment_select #(.W(16), .N(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_m(out_m), .out_c(out_c), .out_seg(out_seg),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready)
    );

    typedef struct {
        logic [4:0]  seg;
        logic [15:0] m;
        logic [15:0] c;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  seg;
        logic [15:0] m;
        logic [15:0] c;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          n_out  = 0;
    logic [15:0] bp_m [16];
    logic [15:0] m_m  [17];
    logic [15:0] c_m  [17];
    exp_t        q[$];
    bit          last_in_fire, last_wr_fire;
    bit          prev_stall;
    logic [36:0] prev_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: interpret sign-magnitude as a plain signed integer.
    function automatic int sm_val(input logic [15:0] x);
        return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
    endfunction

    function automatic exp_t ref_out(input logic [15:0] d);
        exp_t e;
        int   s;
        s = 16;
        for (int j = 15; j >= 0; j--) begin
            if (sm_val(d) < sm_val(bp_m[j])) s = j;
        end
        e.seg = 5'(s);
        e.m   = m_m[s];
        e.c   = c_m[s];
        return e;
    endfunction

    task automatic clear_model();
        for (int j = 0; j < 16; j++) bp_m[j] = 16'h0000;
        for (int j = 0; j < 17; j++) begin
            m_m[j] = 16'h0000;
            c_m[j] = 16'h0000;
        end
        q.delete();
        prev_stall = 1'b0;
    endtask

    // One clock: observe handshakes at the falling edge, return just after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        last_in_fire = in_valid && in_ready && !reset;
        last_wr_fire = wr_en && wr_ready && !reset;
        if (!reset) begin
            if (prev_stall) chk("stall_hold", {out_valid, out_seg, out_m, out_c}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", {out_seg, out_m, out_c}, {e.seg, e.m, e.c});
                end
            end
            if (last_in_fire) q.push_back(ref_out(in_data));
            if (last_wr_fire) begin
                if (wr_sel == 2'd0 && wr_addr < 5'd16) bp_m[wr_addr] = wr_data;
                else if (wr_sel == 2'd1 && wr_addr <= 5'd16) m_m[wr_addr] = wr_data;
                else if (wr_sel == 2'd2 && wr_addr <= 5'd16) c_m[wr_addr] = wr_data;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_seg, out_m, out_c};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [4:0] addr, input logic [15:0] data);
        bit fired;
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        fired = 1'b0;
        for (int i = 0; i < 50 && !fired; i++) begin
            step();
            fired = last_wr_fire;
        end
        if (!fired) chk("wr_timeout", 64'd0, 64'd1);
        wr_en = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        bit fired;
        in_valid = 1'b1; in_data = d;
        fired = 1'b0;
        for (int i = 0; i < 50 && !fired; i++) begin
            step();
            fired = last_in_fire;
        end
        if (!fired) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() > 0 || out_valid); i++) step();
        chk("drained", 64'(q.size()), 64'd0);
    endtask

    logic [15:0] fp16_bp [16];
    vec_t        vecs [6];
    int          n0, acc;

    initial begin
        fp16_bp = '{16'hC800, 16'hC700, 16'hC600, 16'hC500, 16'hC400, 16'hC200, 16'hC000, 16'hBC00,
                    16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700};
        vecs[0] = '{16'h0000, 5'd9,  16'h0009, 16'h0109};
        vecs[1] = '{16'hC800, 5'd1,  16'h0001, 16'h0101};
        vecs[2] = '{16'hCC00, 5'd0,  16'h0000, 16'h0100};
        vecs[3] = '{16'h4800, 5'd16, 16'h0010, 16'h0110};
        vecs[4] = '{16'h8000, 5'd9,  16'h0009, 16'h0109};
        vecs[5] = '{16'h4700, 5'd16, 16'h0010, 16'h0110};

        reset = 1'b1; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1;
        wr_en = 1'b0; wr_sel = 2'd0; wr_addr = 5'd0; wr_data = 16'h0000;
        clear_model();
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_m",     64'(out_m),     64'd0);
        chk("rst_out_c",     64'(out_c),     64'd0);
        chk("rst_out_seg",   64'(out_seg),   64'd0);
        reset = 1'b0;
        #1;
        chk("idle_wr_ready", 64'(wr_ready), 64'd1);

        for (int j = 0; j < 16; j++) wr(2'd0, 5'(j), fp16_bp[j]);
        for (int j = 0; j < 17; j++) begin
            wr(2'd1, 5'(j), 16'(j));
            wr(2'd2, 5'(j), 16'(16'h0100 + j));
        end

        // Directed vectors with latency: result visible in the second cycle after accept.
        foreach (vecs[i]) begin
            send(vecs[i].data);
            chk("lat_early", 64'(out_valid), 64'd0);
            step();
            chk("lat_valid", 64'(out_valid), 64'd1);
            chk("vec", {out_seg, out_m, out_c}, {vecs[i].seg, vecs[i].m, vecs[i].c});
            step();
        end
        drain();

        // 32 back-to-back samples at full throughput.
        n0 = n_out;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : fp16_bp[$urandom_range(0, 15)];
            chk("stream_ready", 64'(in_ready), 64'd1);
            if (i >= 2) chk("stream_valid", 64'(out_valid), 64'd1);
            step();
        end
        in_valid = 1'b0;
        drain();
        chk("stream_count", 64'(n_out - n0), 64'd32);

        // Backpressure from an empty pipeline: two accepts, then stall with held outputs.
        n0 = n_out;
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            step();
            if (last_in_fire) acc++;
        end
        chk("stall_accepts", 64'(acc), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'($urandom);
            step();
            if (last_in_fire) acc++;
        end
        in_valid = 1'b0;
        drain();
        chk("stall_count", 64'(n_out - n0), 64'(acc));

        // Random valid/ready traffic.
        for (int i = 0; i < 120; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : fp16_bp[$urandom_range(0, 15)];
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();

        // Write blocked while busy, then applied to the next sample.
        in_valid = 1'b1; in_data = 16'h4400;
        step();
        in_valid = 1'b0;
        wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 5'd9; wr_data = 16'h0ABC;
        #1;
        chk("busy_wr_ready", 64'(wr_ready), 64'd0);
        wr(2'd1, 5'd9, 16'h0ABC);
        send(16'h0000);
        step();
        chk("new_m", {out_seg, out_m}, {5'd9, 16'h0ABC});
        drain();

        // Sample and write offered together: the sample wins.
        in_valid = 1'b1; in_data = 16'h3C00;
        wr_en = 1'b1; wr_sel = 2'd2; wr_addr = 5'd10; wr_data = 16'h0777;
        #1;
        chk("tie_wr_ready", 64'(wr_ready), 64'd0);
        step();
        chk("tie_fires", {last_in_fire, last_wr_fire}, {1'b1, 1'b0});
        in_valid = 1'b0;
        wr(2'd2, 5'd10, 16'h0777);
        drain();

        // Dropped writes leave the table untouched.
        wr(2'd3, 5'd9,  16'hFFFF);
        wr(2'd0, 5'd16, 16'h0000);
        wr(2'd1, 5'd17, 16'h5555);
        wr(2'd2, 5'd20, 16'h5555);
        send(16'h0000);
        step();
        chk("drop_sel3", {out_seg, out_m, out_c}, {5'd9, 16'h0ABC, 16'h0109});
        send(16'h4800);
        step();
        chk("drop_addr", {out_seg, out_m, out_c}, {5'd16, 16'h0010, 16'h0110});
        send(16'h3C00);
        step();
        chk("new_c", {out_seg, out_c}, {5'd10, 16'h0777});
        drain();

        // Reset with two samples in flight.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h0000;
        step();
        in_data = 16'h4800;
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_data", {out_seg, out_m, out_c}, 64'd0);
        clear_model();
        step(); step();
        reset = 1'b0;
        send(16'h3C00);
        step();
        chk("post_rst", {out_valid, out_seg, out_m, out_c}, {1'b1, 5'd16, 16'h0000, 16'h0000});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
